// File: rtl/stage3_ex_if.sv
`default_nettype none
// ============================================================================
// Module      : stage3_ex_if
// Description : Bundles the ID/EX inputs, forwarding inputs and EX/MEM outputs
//               of the execute stage.
//               slave  - the execute stage's view (ID/EX in, EX/MEM out)
//               master - the view of whoever drives the stage
// Revision    : 1.0 - initial release
// ============================================================================
interface stage3_ex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // ID/EX side
  logic [DATA_WIDTH-1:0] pc_plus4_in;
  logic [DATA_WIDTH-1:0] regA_rd_data;
  logic [DATA_WIDTH-1:0] regB_rd_data;
  logic [DATA_WIDTH-1:0] imm_exted;
  logic [ADDR_WIDTH-1:0] regT_addr;
  logic [ADDR_WIDTH-1:0] regD_addr;
  logic [3:0]            alu_op;
  logic                  alu_src;
  logic                  reg_dst;
  logic                  reg_wr_en_in;
  logic [1:0]            mem_ctrl_in;
  // Forwarding and multiply control
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [DATA_WIDTH-1:0] fwd_mem_data;
  logic [DATA_WIDTH-1:0] fwd_wb_data;
  logic                  md_start;
  // EX/MEM side
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] store_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  zero;
  logic [DATA_WIDTH-1:0] pc_plus4_out;
  logic                  reg_wr_en_out;
  logic [1:0]            mem_ctrl_out;
  logic                  md_busy;

  modport slave (
    input  pc_plus4_in, regA_rd_data, regB_rd_data, imm_exted,
           regT_addr, regD_addr, alu_op, alu_src, reg_dst,
           reg_wr_en_in, mem_ctrl_in, fwd_a, fwd_b,
           fwd_mem_data, fwd_wb_data, md_start,
    output alu_result, store_data, wr_addr, branch_target, zero,
           pc_plus4_out, reg_wr_en_out, mem_ctrl_out, md_busy
  );

  modport master (
    output pc_plus4_in, regA_rd_data, regB_rd_data, imm_exted,
           regT_addr, regD_addr, alu_op, alu_src, reg_dst,
           reg_wr_en_in, mem_ctrl_in, fwd_a, fwd_b,
           fwd_mem_data, fwd_wb_data, md_start,
    input  alu_result, store_data, wr_addr, branch_target, zero,
           pc_plus4_out, reg_wr_en_out, mem_ctrl_out, md_busy
  );
endinterface
`default_nettype wire

// File: rtl/stage3_ex.sv
`default_nettype none
// ============================================================================
// Module      : stage3_ex
// Description : Execute stage of a 5-stage MIPS-style pipeline. Forwarding
//               muxes, ALU, branch target, zero flag, destination select,
//               iterative 32-cycle unsigned multiplier with HI/LO, and the
//               EX/MEM pipeline register.
// Ports       : clk  - rising-edge clock
//               rstb - asynchronous active-low reset
//               ex   - stage3_ex_if.slave (ID/EX inputs, forwarding inputs,
//                      md_start, EX/MEM outputs, md_busy)
// Revision    : 1.0 - initial release
// ============================================================================
module stage3_ex #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  wire logic   clk,
  input  wire logic   rstb,
  stage3_ex_if.slave  ex
);

  localparam int                 CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam int                 PROD_W   = 2 * DATA_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MFLO = 4'd13;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Forwarding and operand selection
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] a_fwd;
  logic [DATA_WIDTH-1:0] b_fwd;
  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            shamt;

  always_comb begin
    unique case (ex.fwd_a)
      2'b01:   a_fwd = ex.fwd_mem_data;
      2'b10:   a_fwd = ex.fwd_wb_data;
      default: a_fwd = ex.regA_rd_data;
    endcase
    unique case (ex.fwd_b)
      2'b01:   b_fwd = ex.fwd_mem_data;
      2'b10:   b_fwd = ex.fwd_wb_data;
      default: b_fwd = ex.regB_rd_data;
    endcase
  end

  assign op_b  = ex.alu_src ? ex.imm_exted : b_fwd;
  assign shamt = ex.imm_exted[10:6];

  // --------------------------------------------------------------------------
  // Multiplier state
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [PROD_W-1:0]     mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [PROD_W-1:0]     partial;
  logic                  bubble;

  assign partial = mplier_q[0] ? (mcand_q << cnt_q) : '0;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (ex.md_start) begin
          mcand_d  = {{DATA_WIDTH{1'b0}}, a_fwd};
          mplier_d = b_fwd;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // md_start is deliberately not looked at here
        acc_d    = acc_q + partial;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          {hi_d, lo_d} = acc_q + partial;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign ex.md_busy = (state_q == RUN);

  // The multiply instruction and everything stalled behind it must not
  // write the register file or memory.
  assign bubble = (state_q == RUN) || ((state_q == IDLE) && ex.md_start);

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] alu_d;

  always_comb begin
    alu_d = '0;
    unique case (ex.alu_op)
      OP_ADD:  alu_d = a_fwd + op_b;
      OP_SUB:  alu_d = a_fwd - op_b;
      OP_AND:  alu_d = a_fwd & op_b;
      OP_OR:   alu_d = a_fwd | op_b;
      OP_XOR:  alu_d = a_fwd ^ op_b;
      OP_NOR:  alu_d = ~(a_fwd | op_b);
      OP_SLT:  alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_fwd) < $signed(op_b))};
      OP_SLTU: alu_d = {{(DATA_WIDTH-1){1'b0}}, (a_fwd < op_b)};
      OP_SLL:  alu_d = op_b << shamt;
      OP_SRL:  alu_d = op_b >> shamt;
      OP_SRA:  alu_d = $unsigned($signed(op_b) >>> shamt);
      OP_LUI:  alu_d = {ex.imm_exted[15:0], {(DATA_WIDTH-16){1'b0}}};
      OP_MFHI: alu_d = hi_q;
      OP_MFLO: alu_d = lo_q;
      default: alu_d = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] alu_result_q;
  logic [DATA_WIDTH-1:0] store_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] branch_target_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] pc_plus4_q;
  logic                  reg_wr_en_q;
  logic [1:0]            mem_ctrl_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      alu_result_q    <= '0;
      store_data_q    <= '0;
      wr_addr_q       <= '0;
      branch_target_q <= '0;
      zero_q          <= 1'b0;
      pc_plus4_q      <= '0;
      reg_wr_en_q     <= 1'b0;
      mem_ctrl_q      <= 2'b00;
    end else begin
      alu_result_q    <= alu_d;
      store_data_q    <= b_fwd;
      wr_addr_q       <= ex.reg_dst ? ex.regD_addr : ex.regT_addr;
      branch_target_q <= ex.pc_plus4_in + {ex.imm_exted[DATA_WIDTH-3:0], 2'b00};
      zero_q          <= (a_fwd == b_fwd);
      pc_plus4_q      <= ex.pc_plus4_in;
      reg_wr_en_q     <= bubble ? 1'b0 : ex.reg_wr_en_in;
      mem_ctrl_q      <= bubble ? 2'b00 : ex.mem_ctrl_in;
    end
  end

  assign ex.alu_result    = alu_result_q;
  assign ex.store_data    = store_data_q;
  assign ex.wr_addr       = wr_addr_q;
  assign ex.branch_target = branch_target_q;
  assign ex.zero          = zero_q;
  assign ex.pc_plus4_out  = pc_plus4_q;
  assign ex.reg_wr_en_out = reg_wr_en_q;
  assign ex.mem_ctrl_out  = mem_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_stage3_ex.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage3_ex
// Description : Self-checking bench for stage3_ex: table of ALU/forwarding/
//               branch vectors through a scoreboard queue, plus hand-written
//               multiply, second-start and abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage3_ex;

  logic clk;
  logic rstb;

  stage3_ex_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  stage3_ex #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) u_dut (
    .clk  (clk),
    .rstb (rstb),
    .ex   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        rd_sel;
    logic [31:0] e_alu;
    logic [31:0] e_store;
    logic [31:0] e_bt;
    logic        e_zero;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] store;
    logic [31:0] bt;
    logic        zero;
    logic [4:0]  wr;
    logic [31:0] pc;
    logic        wen;
    logic [1:0]  mctl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic src,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic rd_sel, input logic [31:0] e_alu,
                              input logic [31:0] e_store, input logic [31:0] e_bt,
                              input logic e_zero);
    vec_t v;
    v.op = op; v.src = src; v.fa = fa; v.fb = fb; v.a = a; v.b = b;
    v.imm = imm; v.pc = pc; v.rd_sel = rd_sel; v.e_alu = e_alu;
    v.e_store = e_store; v.e_bt = e_bt; v.e_zero = e_zero;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu"},   bus.alu_result,    32'h0);
    chk({tag, "_store"}, bus.store_data,    32'h0);
    chk({tag, "_wr"},    32'(bus.wr_addr),  32'h0);
    chk({tag, "_bt"},    bus.branch_target, 32'h0);
    chk({tag, "_zero"},  32'(bus.zero),     32'h0);
    chk({tag, "_pc"},    bus.pc_plus4_out,  32'h0);
    chk({tag, "_wen"},   32'(bus.reg_wr_en_out), 32'h0);
    chk({tag, "_mctl"},  32'(bus.mem_ctrl_out),  32'h0);
    chk({tag, "_busy"},  32'(bus.md_busy),  32'h0);
  endtask

  // Drive one instruction, queue its expected EX/MEM contents, clock it in
  // and compare against the head of the queue.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    exp_t g;
    bus.alu_op       = v.op;
    bus.alu_src      = v.src;
    bus.fwd_a        = v.fa;
    bus.fwd_b        = v.fb;
    bus.regA_rd_data = v.a;
    bus.regB_rd_data = v.b;
    bus.imm_exted    = v.imm;
    bus.pc_plus4_in  = v.pc;
    bus.reg_dst      = v.rd_sel;
    bus.reg_wr_en_in = 1'b1;
    bus.mem_ctrl_in  = 2'b10;
    bus.md_start     = 1'b0;
    e.alu = v.e_alu; e.store = v.e_store; e.bt = v.e_bt; e.zero = v.e_zero;
    e.wr = v.rd_sel ? 5'd7 : 5'd3; e.pc = v.pc; e.wen = 1'b1; e.mctl = 2'b10;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({name, "_alu"},   bus.alu_result,    g.alu);
    chk({name, "_store"}, bus.store_data,    g.store);
    chk({name, "_bt"},    bus.branch_target, g.bt);
    chk({name, "_zero"},  32'(bus.zero),     32'(g.zero));
    chk({name, "_wr"},    32'(bus.wr_addr),  32'(g.wr));
    chk({name, "_pc"},    bus.pc_plus4_out,  g.pc);
    chk({name, "_wen"},   32'(bus.reg_wr_en_out), 32'(g.wen));
    chk({name, "_mctl"},  32'(bus.mem_ctrl_out),  32'(g.mctl));
  endtask

  // Start a multiply; optionally re-pulse md_start mid-run, or abort with
  // reset after abort_at busy cycles.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input bit restart, input int abort_at, input string name);
    int busy;
    bus.regA_rd_data = a;
    bus.regB_rd_data = b;
    bus.fwd_a        = 2'b00;
    bus.fwd_b        = 2'b00;
    bus.alu_src      = 1'b0;
    bus.alu_op       = 4'd0;
    bus.reg_wr_en_in = 1'b1;
    bus.mem_ctrl_in  = 2'b11;
    bus.md_start     = 1'b1;
    @(posedge clk);
    #1;
    bus.md_start = 1'b0;
    chk({name, "_start_wen"},  32'(bus.reg_wr_en_out), 32'h0);
    chk({name, "_start_mctl"}, 32'(bus.mem_ctrl_out),  32'h0);
    busy = 0;
    while (bus.md_busy && busy < 100) begin
      busy++;
      chk({name, "_busy_wen"}, 32'(bus.reg_wr_en_out), 32'h0);
      if (abort_at != 0 && busy == abort_at) begin
        rstb = 1'b0;
        #2;
        chk({name, "_abort_busy"}, 32'(bus.md_busy), 32'h0);
        chk({name, "_abort_alu"},  bus.alu_result,   32'h0);
        #2;
        rstb = 1'b1;
        break;
      end
      if (restart && busy == 5) begin
        bus.regA_rd_data = 32'd3;
        bus.regB_rd_data = 32'd4;
        bus.md_start     = 1'b1;
      end else begin
        bus.md_start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.md_start = 1'b0;
    if (abort_at == 0) chk({name, "_busy_cycles"}, 32'(busy), 32'd32);
  endtask

  initial begin
    bus.pc_plus4_in  = '0;
    bus.regA_rd_data = '0;
    bus.regB_rd_data = '0;
    bus.imm_exted    = '0;
    bus.regT_addr    = 5'd3;
    bus.regD_addr    = 5'd7;
    bus.alu_op       = '0;
    bus.alu_src      = 1'b0;
    bus.reg_dst      = 1'b0;
    bus.reg_wr_en_in = 1'b0;
    bus.mem_ctrl_in  = 2'b00;
    bus.fwd_a        = 2'b00;
    bus.fwd_b        = 2'b00;
    bus.fwd_mem_data = 32'h10;
    bus.fwd_wb_data  = 32'h20;
    bus.md_start     = 1'b0;

    //          op     src  fa     fb     a             b             imm           pc          rd  alu           store         bt          z
    tbl[0]  = mk(4'd0,  0, 2'b00, 2'b00, 32'd5,        32'd7,        32'h0,        32'h0,      0, 32'd12,       32'd7,        32'h0,      0);
    tbl[1]  = mk(4'd0,  0, 2'b01, 2'b00, 32'd1,        32'd0,        32'h0,        32'h0,      0, 32'h10,       32'h0,        32'h0,      0);
    tbl[2]  = mk(4'd0,  0, 2'b10, 2'b00, 32'd1,        32'd0,        32'h0,        32'h0,      0, 32'h20,       32'h0,        32'h0,      0);
    tbl[3]  = mk(4'd0,  0, 2'b11, 2'b00, 32'd1,        32'd0,        32'h0,        32'h0,      0, 32'h1,        32'h0,        32'h0,      0);
    tbl[4]  = mk(4'd1,  0, 2'b00, 2'b00, 32'd0,        32'd1,        32'h0,        32'h0,      0, 32'hFFFFFFFF, 32'h1,        32'h0,      0);
    tbl[5]  = mk(4'd6,  0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,      0, 32'h1,        32'h1,        32'h0,      0);
    tbl[6]  = mk(4'd7,  0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,      0, 32'h0,        32'h1,        32'h0,      0);
    tbl[7]  = mk(4'd10, 0, 2'b00, 2'b00, 32'd0,        32'h80000000, 32'h100,      32'h0,      0, 32'hF8000000, 32'h80000000, 32'h400,    0);
    tbl[8]  = mk(4'd11, 1, 2'b00, 2'b00, 32'd0,        32'd0,        32'h1234,     32'h0,      0, 32'h12340000, 32'h0,        32'h48D0,   1);
    tbl[9]  = mk(4'd0,  0, 2'b00, 2'b00, 32'd9,        32'd9,        32'hFFFFFFFF, 32'h100,    1, 32'd18,       32'd9,        32'hFC,     1);
    tbl[10] = mk(4'd3,  0, 2'b00, 2'b01, 32'd0,        32'd3,        32'h0,        32'h0,      1, 32'h10,       32'h10,       32'h0,      0);
    tbl[11] = mk(4'd4,  0, 2'b00, 2'b10, 32'h30,       32'd3,        32'h0,        32'h0,      0, 32'h10,       32'h20,       32'h0,      0);
    tbl[12] = mk(4'd0,  1, 2'b00, 2'b00, 32'd5,        32'd9,        32'h3,        32'h0,      0, 32'd8,        32'd9,        32'hC,      0);
    tbl[13] = mk(4'd5,  0, 2'b00, 2'b00, 32'd0,        32'd0,        32'h0,        32'h0,      0, 32'hFFFFFFFF, 32'h0,        32'h0,      1);
    tbl[14] = mk(4'd8,  0, 2'b00, 2'b00, 32'd0,        32'd1,        32'h7C0,      32'h0,      0, 32'h80000000, 32'h1,        32'h1F00,   0);
    tbl[15] = mk(4'd14, 0, 2'b00, 2'b00, 32'd2,        32'd2,        32'h0,        32'h0,      1, 32'h0,        32'h2,        32'h0,      1);

    // Reset state
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_init");
    rstb = 1'b1;

    // First instruction, then reset in the middle of the stream
    apply(tbl[0], "add_pre");
    rstb = 1'b0;
    #2;
    chk_reset_outputs("rst_mid");
    #2;
    rstb = 1'b1;

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Full-width multiply with an ignored second md_start mid-run
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, "mul_ff");
    apply(mk(4'd12, 0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'hFFFFFFFE, 32'h0, 32'h0, 1), "mfhi_ff");
    apply(mk(4'd13, 0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h00000001, 32'h0, 32'h0, 1), "mflo_ff");

    // Abort at busy cycle 10: hi/lo return to zero
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 10, "mul_abort");
    apply(mk(4'd12, 0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1), "mfhi_abort");
    apply(mk(4'd13, 0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1), "mflo_abort");

    // Small multiply after the abort
    run_mul(32'd3, 32'd4, 1'b0, 0, "mul_3x4");
    apply(mk(4'd13, 0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'd12, 32'h0, 32'h0, 1), "mflo_3x4");
    apply(mk(4'd12, 0, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'd0,  32'h0, 32'h0, 1), "mfhi_3x4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage3_ex.md
Name: stage3_ex

Overview:
- Execute stage of the 5-stage MIPS-style pipeline. Sits directly downstream of the decode stage and consumes its ID/EX register outputs: PC+4, read data A/B, extended immediate, and S/T/D register addresses.
- Applies forwarding muxes, computes the ALU result, branch target and zero flag, and selects the destination register.
- Contains an iterative 32-cycle unsigned multiplier with HI/LO registers and a busy/stall signal for the hazard unit.
- Registers all results into the EX/MEM pipeline register.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstb  in  1  asynchronous active-low reset.
- pc_plus4_in  in  DATA_WIDTH  PC+4 from ID/EX.
- regA_rd_data  in  DATA_WIDTH  rs data from ID/EX.
- regB_rd_data  in  DATA_WIDTH  rt data from ID/EX.
- imm_exted  in  DATA_WIDTH  extended immediate from ID/EX.
- regT_addr  in  ADDR_WIDTH  rt address.
- regD_addr  in  ADDR_WIDTH  rd address.
- alu_op  in  4  operation code (see Behaviour).
- alu_src  in  1  1 selects imm_exted as operand B.
- reg_dst  in  1  1 selects regD_addr as destination, 0 selects regT_addr.
- reg_wr_en_in  in  1  register-write control, passed through.
- mem_ctrl_in  in  2  {mem_rd, mem_wr}, passed through.
- fwd_a  in  2  operand A source select.
- fwd_b  in  2  operand B source select.
- fwd_mem_data  in  DATA_WIDTH  forwarded EX/MEM result.
- fwd_wb_data  in  DATA_WIDTH  forwarded writeback data.
- md_start  in  1  start multiply.
- alu_result  out  DATA_WIDTH  registered ALU result.
- store_data  out  DATA_WIDTH  registered forwarded operand B (pre-immediate-mux).
- wr_addr  out  ADDR_WIDTH  registered destination register.
- branch_target  out  DATA_WIDTH  registered branch target.
- zero  out  1  registered (A_fwd == B_fwd).
- pc_plus4_out  out  DATA_WIDTH  registered PC+4.
- reg_wr_en_out  out  1  registered register-write control.
- mem_ctrl_out  out  2  registered memory control.
- md_busy  out  1  multiplier busy; the hazard unit stalls IF/ID/EX while this is high.

Behaviour:
- Reset: all outputs 0, hi = lo = 0, FSM in IDLE. Asserting rstb low mid-multiply aborts the operation; hi/lo go to 0.
- Forwarding (fwd_a/fwd_b): 00 = regA_rd_data / regB_rd_data; 01 = fwd_mem_data; 10 = fwd_wb_data; 11 behaves as 00. Results are A_fwd and B_fwd.
- Operand B = alu_src ? imm_exted : B_fwd.
- ALU codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: operand B shifted by imm_exted[10:6].
  - 11 LUI: {imm_exted[15:0], 16'h0}.
  - 12 MFHI, 13 MFLO.
  - 14–15 produce 0.
- Arithmetic: ADD/SUB wrap modulo 2^32; no overflow trap.
- branch_target = pc_plus4_in + (imm_exted << 2), truncated to DATA_WIDTH.
- wr_addr = reg_dst ? regD_addr : regT_addr.
- Latency: one cycle; all outputs are registered on the EX/MEM edge.
- Multiplier FSM states: IDLE, RUN.
  - IDLE, md_start = 1: capture mcand = A_fwd, mplier = B_fwd, acc = 0, cnt = 0; go to RUN.
  - RUN: each cycle, if mplier[0] then acc += mcand << cnt (64-bit); mplier >>= 1; cnt++.
  - After the cnt = 31 step, write {hi, lo} = final acc and return to IDLE.
  - md_busy = (state == RUN), so it is high for exactly 32 cycles starting the cycle after md_start is sampled.
  - md_start is ignored while in RUN.
- Bubble rule: in the md_start cycle and every md_busy cycle, EX/MEM captures reg_wr_en_out = 0 and mem_ctrl_out = 0; data fields update normally. The multiply instruction itself never writes the register file.
- MFHI/MFLO return the current hi/lo. Issuing them while md_busy is the hazard unit's responsibility; the block returns the stale value.
- Unsigned product only; the full 64-bit result is exact.

Test Plan:
- Reset: rstb low mid-stream -> all outputs 0, md_busy = 0; after release, ADD of 5 + 7 with fwd = 00 -> alu_result = 12 one cycle later.
- Forwarding: regA = 1, fwd_mem_data = 0x10, fwd_wb_data = 0x20; ADD with regB = 0:
  - fwd_a = 01 -> alu_result = 0x10.
  - fwd_a = 10 -> alu_result = 0x20.
  - fwd_a = 11 -> alu_result = 1.
- ALU edges:
  - SUB 0 − 1 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF, 1 -> 1; SLTU 0xFFFFFFFF, 1 -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - LUI imm 0x1234 -> 0x12340000.
- Branch and destination: pc_plus4 = 0x100, imm = 0xFFFFFFFF -> branch_target = 0xFC; A = B = 9 -> zero = 1; reg_dst = 1, rd = 7 -> wr_addr = 7.
- Multiply: md_start with A = 0xFFFFFFFF, B = 0xFFFFFFFF ->
  - md_busy high for exactly 32 cycles, reg_wr_en_out = 0 throughout.
  - Then MFHI = 0xFFFFFFFE, MFLO = 0x00000001.
  - A second md_start during RUN is ignored.
- Abort: reset asserted at cycle 10 of RUN -> md_busy = 0 and hi = lo = 0 immediately. A new multiply 3 × 4 -> MFLO = 12, MFHI = 0.
